// File: rtl/ahb_sram_slave_if_if.sv
// Bus bundle between an AHB-Lite master, the SRAM front end and the SRAM controller.
// The slave modport is the front end's view; the master modport drives the bus and the SRAM acks.
`timescale 1ns/1ps
interface ahb_sram_slave_if_if #(
  parameter int unsigned AHB_DWIDTH = 32,
  parameter int unsigned ADD_WIDTH  = 11
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [AHB_DWIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [AHB_DWIDTH-1:0] HRDATA;

  logic                  ahbsram_req;
  logic                  ahbsram_write;
  logic [2:0]            ahbsram_size;
  logic [ADD_WIDTH-1:0]  ahbsram_addr;
  logic [AHB_DWIDTH-1:0] ahbsram_wdata;
  logic                  sramahb_ack;
  logic [AHB_DWIDTH-1:0] sramahb_rdata;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
    input  sramahb_ack, sramahb_rdata
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
    output sramahb_ack, sramahb_rdata
  );
endinterface

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave front end: turns bus transfers into single-pulse SRAM requests, stalls the
// bus until the SRAM controller acks, and answers illegal size/alignment with a 2-cycle ERROR.
`timescale 1ns/1ps
module ahb_sram_slave_if #(
  parameter int unsigned AHB_DWIDTH = 32,
  parameter int unsigned ADD_WIDTH  = 11
) (
  input logic                HCLK,
  input logic                HRESETN,
  ahb_sram_slave_if_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StErr1 = 3'd3,
    StErr2 = 3'd4
  } state_e;

  state_e               state_q;
  logic                 hreadyout_q;
  logic                 hresp_q;
  logic                 req_q;
  logic                 write_q;
  logic [2:0]           size_q;
  logic [ADD_WIDTH-1:0] addr_q;

  logic addr_valid;
  logic size_illegal;
  logic align_illegal;
  logic xfer_illegal;
  logic unused_bus;

  assign addr_valid    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign size_illegal  = (bus.HSIZE > 3'b010);
  assign align_illegal = ((bus.HSIZE == 3'b001) && bus.HADDR[0]) ||
                         ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
  assign xfer_illegal  = size_illegal | align_illegal;

  // Only the SRAM-sized part of the address and the NONSEQ/SEQ bit of HTRANS matter here.
  assign unused_bus = ^{bus.HADDR[31:ADD_WIDTH], bus.HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= StIdle;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      req_q       <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      addr_q      <= '0;
    end else begin
      unique case (state_q)
        // The second error cycle is also an address-phase slot, so it shares the idle decode.
        StIdle, StErr2: begin
          req_q <= 1'b0;
          if (addr_valid && xfer_illegal) begin
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
            state_q     <= StErr1;
          end else if (addr_valid) begin
            write_q     <= bus.HWRITE;
            size_q      <= bus.HSIZE;
            addr_q      <= bus.HADDR[ADD_WIDTH-1:0];
            req_q       <= 1'b1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b0;
            state_q     <= StReq;
          end else begin
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StReq: begin
          req_q <= 1'b0;
          if (bus.sramahb_ack) begin
            hreadyout_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.sramahb_ack) begin
            hreadyout_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StErr1: begin
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
          state_q     <= StErr2;
        end
        default: begin
          req_q       <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.HREADYOUT     = hreadyout_q;
  assign bus.HRESP         = hresp_q;
  assign bus.HRDATA        = bus.sramahb_rdata;
  assign bus.ahbsram_req   = req_q;
  assign bus.ahbsram_write = write_q;
  assign bus.ahbsram_size  = size_q;
  assign bus.ahbsram_addr  = addr_q;
  assign bus.ahbsram_wdata = bus.HWDATA;

endmodule

// File: tb/tb_ahb_sram_slave_if.sv
// Bench for ahb_sram_slave_if: pipelined AHB master driver, byte-lane SRAM model with a
// programmable ack delay, and a request scoreboard checked on every ahbsram_req pulse.
`timescale 1ns/1ps
module tb_ahb_sram_slave_if;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_req;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } xfer_t;

  typedef struct {
    logic        write;
    logic [2:0]  size;
    logic [10:0] addr;
  } req_t;

  localparam logic [1:0] TrIdle = 2'b00;
  localparam logic [1:0] TrBusy = 2'b01;
  localparam logic [1:0] TrNseq = 2'b10;
  localparam logic [1:0] TrSeq  = 2'b11;
  localparam logic [2:0] SzB    = 3'b000;
  localparam logic [2:0] SzH    = 3'b001;
  localparam logic [2:0] SzW    = 3'b010;

  logic HCLK;
  logic HRESETN;
  logic hready_kill;

  int   checks     = 0;
  int   fails      = 0;
  int   req_total  = 0;
  int   cyc_cnt    = 0;
  int   ack_delay  = 1;

  xfer_t pend[$];
  req_t  exp_req_q[$];
  int    req_cycles[$];
  logic [7:0] mem [2048];

  ahb_sram_slave_if_if #(.AHB_DWIDTH(32), .ADD_WIDTH(11)) bus ();

  ahb_sram_slave_if #(.AHB_DWIDTH(32), .ADD_WIDTH(11)) dut (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .bus     (bus)
  );

  assign bus.HREADY = bus.HREADYOUT & ~hready_kill;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic write,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic exp_req,
                               input logic exp_err, input logic chk_rd,
                               input logic [31:0] exp_rdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write; x.size = size; x.addr = addr;
    x.wdata = wdata; x.exp_req = exp_req; x.exp_err = exp_err; x.chk_rd = chk_rd;
    x.exp_rdata = exp_rdata;
    return x;
  endfunction

  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HTRANS = TrIdle; bus.HWRITE = 1'b0; bus.HSIZE = SzB;
    bus.HADDR = 32'h0;
  endtask

  task automatic drive_addr(input xfer_t x);
    bus.HSEL = x.sel; bus.HTRANS = x.trans; bus.HWRITE = x.write; bus.HSIZE = x.size;
    bus.HADDR = x.addr;
  endtask

  task automatic push_exp_req(input xfer_t x);
    req_t r;
    r.write = x.write; r.size = x.size; r.addr = x.addr[10:0];
    exp_req_q.push_back(r);
  endtask

  // Drives everything queued in pend as a pipelined AHB stream; each data phase is checked
  // in the cycle where HREADYOUT is high, and every stalled cycle is checked for HRESP.
  task automatic run_xfers(input string tag);
    xfer_t dp;
    logic  dp_v;
    int    waits;
    int    cyc;
    dp_v = 1'b0; waits = 0; cyc = 0;
    forever begin
      @(negedge HCLK);
      cyc++;
      if (dp_v) bus.HWDATA = dp.wdata;
      if (bus.HREADYOUT !== 1'b1) begin
        waits++;
        if (dp_v) check({tag, "_hresp_stall"}, 32'(bus.HRESP), 32'(dp.exp_err));
      end else begin
        if (dp_v) begin
          check({tag, "_hresp"}, 32'(bus.HRESP), 32'(dp.exp_err));
          check({tag, "_waits"}, 32'(waits),
                32'(dp.exp_err ? 1 : (dp.exp_req ? ack_delay + 1 : 0)));
          if (dp.chk_rd) check({tag, "_rdata"}, bus.HRDATA, dp.exp_rdata);
        end
        dp_v = 1'b0; waits = 0;
        if (pend.size() == 0) begin
          drive_idle();
          break;
        end
        dp = pend.pop_front();
        dp_v = 1'b1;
        drive_addr(dp);
        if (dp.exp_req) push_exp_req(dp);
      end
      if (cyc > 200) begin
        checks++; fails++;
        $display("FAIL %s_timeout: HREADYOUT=%0b after %0d cycles, required 1", tag,
                 bus.HREADYOUT, cyc);
        drive_idle();
        pend.delete();
        break;
      end
    end
  endtask

  // Request monitor / scoreboard.
  initial begin
    logic prev;
    req_t r;
    prev = 1'b0;
    forever begin
      @(negedge HCLK);
      if (bus.ahbsram_req === 1'b1) begin
        req_total++;
        req_cycles.push_back(cyc_cnt);
        check("req_single_pulse", 32'(prev), 32'(0));
        if (exp_req_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_req: req=1 addr=0x%03h, required no request",
                   bus.ahbsram_addr);
        end else begin
          r = exp_req_q.pop_front();
          check("req_write", 32'(bus.ahbsram_write), 32'(r.write));
          check("req_size", 32'(bus.ahbsram_size), 32'(r.size));
          check("req_addr", 32'(bus.ahbsram_addr), 32'(r.addr));
        end
      end
      prev = bus.ahbsram_req;
    end
  end

  // SRAM controller model: ack ack_delay cycles after the request, data valid after the ack.
  initial begin
    logic        p_write;
    logic [2:0]  p_size;
    logic [10:0] p_addr;
    logic [10:0] a;
    logic        pend_op;
    logic        en;
    int          cnt;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    bus.sramahb_ack = 1'b0; bus.sramahb_rdata = 32'h0;
    p_write = 1'b0; p_size = 3'b0; p_addr = '0; pend_op = 1'b0; cnt = 0;
    forever begin
      @(posedge HCLK);
      if (bus.sramahb_ack) begin
        a = {p_addr[10:2], 2'b00};
        if (p_write) begin
          for (int i = 0; i < 4; i++) begin
            en = (p_size == SzW) || (p_size == SzH && i[1] == p_addr[1]) ||
                 (p_size == SzB && i[1:0] == p_addr[1:0]);
            if (en) mem[a + 11'(i)] = bus.ahbsram_wdata[8*i +: 8];
          end
        end else begin
          bus.sramahb_rdata <= {mem[a + 11'd3], mem[a + 11'd2], mem[a + 11'd1], mem[a]};
        end
      end
      bus.sramahb_ack <= 1'b0;
      if (bus.ahbsram_req) begin
        p_write = bus.ahbsram_write; p_size = bus.ahbsram_size; p_addr = bus.ahbsram_addr;
        if (ack_delay <= 1) bus.sramahb_ack <= 1'b1;
        else begin
          pend_op = 1'b1; cnt = ack_delay - 1;
        end
      end else if (pend_op) begin
        if (cnt <= 1) begin
          bus.sramahb_ack <= 1'b1; pend_op = 1'b0;
        end else cnt--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    xfer_t vec [16];
    int    base;
    int    rc0;
    logic  seen;

    vec[0]  = mk(1, TrNseq, 1, SzW, 32'h010, 32'hDEADBEEF, 1, 0, 0, 32'h0);
    vec[1]  = mk(1, TrNseq, 0, SzW, 32'h010, 32'h0,        1, 0, 1, 32'hDEADBEEF);
    vec[2]  = mk(1, TrNseq, 1, SzB, 32'h020, 32'h00000011, 1, 0, 0, 32'h0);
    vec[3]  = mk(1, TrNseq, 1, SzB, 32'h021, 32'h00002200, 1, 0, 0, 32'h0);
    vec[4]  = mk(1, TrSeq,  1, SzB, 32'h022, 32'h00330000, 1, 0, 0, 32'h0);
    vec[5]  = mk(1, TrSeq,  1, SzB, 32'h023, 32'h44000000, 1, 0, 0, 32'h0);
    vec[6]  = mk(1, TrNseq, 0, SzW, 32'h020, 32'h0,        1, 0, 1, 32'h44332211);
    vec[7]  = mk(1, TrNseq, 1, SzH, 32'h031, 32'h12345678, 0, 1, 0, 32'h0);
    vec[8]  = mk(1, TrNseq, 1, SzW, 32'h042, 32'h12345678, 0, 1, 0, 32'h0);
    vec[9]  = mk(1, TrNseq, 0, 3'b011, 32'h050, 32'h0,     0, 1, 0, 32'h0);
    vec[10] = mk(1, TrIdle, 0, SzW, 32'h010, 32'h0,        0, 0, 0, 32'h0);
    vec[11] = mk(1, TrBusy, 0, SzW, 32'h010, 32'h0,        0, 0, 0, 32'h0);
    vec[12] = mk(0, TrNseq, 1, SzW, 32'h010, 32'h0,        0, 0, 0, 32'h0);
    vec[13] = mk(1, TrNseq, 1, SzH, 32'h034, 32'h0000CAFE, 1, 0, 0, 32'h0);
    vec[14] = mk(1, TrNseq, 1, SzH, 32'h036, 32'hBEEF0000, 1, 0, 0, 32'h0);
    vec[15] = mk(1, TrNseq, 0, SzW, 32'hF834, 32'h0,       1, 0, 1, 32'hBEEFCAFE);

    HRESETN = 1'b0; hready_kill = 1'b0; bus.HWDATA = 32'h0;
    drive_idle();
    repeat (2) @(negedge HCLK);
    check("reset_hreadyout", 32'(bus.HREADYOUT), 32'(1));
    check("reset_hresp", 32'(bus.HRESP), 32'(0));
    check("reset_req", 32'(bus.ahbsram_req), 32'(0));
    check("reset_addr", 32'(bus.ahbsram_addr), 32'(0));
    HRESETN = 1'b1;
    @(negedge HCLK);
    check("post_reset_hreadyout", 32'(bus.HREADYOUT), 32'(1));

    for (int i = 0; i < 16; i++) begin
      base = req_total;
      pend.push_back(vec[i]);
      run_xfers($sformatf("v%0d", i));
      check($sformatf("v%0d_req_count", i), 32'(req_total - base), 32'(vec[i].exp_req));
      @(negedge HCLK);
      check($sformatf("v%0d_after_hreadyout", i), 32'(bus.HREADYOUT), 32'(1));
      check($sformatf("v%0d_after_hresp", i), 32'(bus.HRESP), 32'(0));
    end

    // Pipelined bursts: each address rides in the previous transfer's final cycle.
    pend.push_back(mk(1, TrNseq, 1, SzW, 32'h000, 32'hA0A0A0A0, 1, 0, 0, 32'h0));
    pend.push_back(mk(1, TrSeq,  1, SzW, 32'h004, 32'hB1B1B1B1, 1, 0, 0, 32'h0));
    pend.push_back(mk(1, TrSeq,  1, SzW, 32'h008, 32'hC2C2C2C2, 1, 0, 0, 32'h0));
    run_xfers("pw");
    rc0 = req_cycles.size();
    pend.push_back(mk(1, TrNseq, 0, SzW, 32'h000, 32'h0, 1, 0, 1, 32'hA0A0A0A0));
    pend.push_back(mk(1, TrSeq,  0, SzW, 32'h004, 32'h0, 1, 0, 1, 32'hB1B1B1B1));
    pend.push_back(mk(1, TrSeq,  0, SzW, 32'h008, 32'h0, 1, 0, 1, 32'hC2C2C2C2));
    run_xfers("pr");
    check("pr_req_count", 32'(req_cycles.size() - rc0), 32'(3));
    if (req_cycles.size() >= rc0 + 3) begin
      check("pr_gap1", 32'(req_cycles[rc0 + 1] - req_cycles[rc0]), 32'(3));
      check("pr_gap2", 32'(req_cycles[rc0 + 2] - req_cycles[rc0 + 1]), 32'(3));
    end

    // Illegal transfer accepted in the second error cycle, then a legal one.
    base = req_total;
    pend.push_back(mk(1, TrNseq, 1, SzH, 32'h031, 32'h0, 0, 1, 0, 32'h0));
    pend.push_back(mk(1, TrNseq, 0, SzW, 32'h002, 32'h0, 0, 1, 0, 32'h0));
    pend.push_back(mk(1, TrNseq, 0, SzW, 32'h004, 32'h0, 1, 0, 1, 32'hB1B1B1B1));
    run_xfers("pe");
    check("pe_req_count", 32'(req_total - base), 32'(1));

    // Slower SRAM: stall length follows the ack.
    ack_delay = 3;
    pend.push_back(mk(1, TrNseq, 0, SzW, 32'h008, 32'h0, 1, 0, 1, 32'hC2C2C2C2));
    run_xfers("ad");
    ack_delay = 1;

    // Address phase while HREADY is low must be ignored.
    base = req_total;
    @(negedge HCLK);
    hready_kill = 1'b1;
    drive_addr(mk(1, TrNseq, 0, SzW, 32'h010, 32'h0, 0, 0, 0, 32'h0));
    @(negedge HCLK);
    check("hready_low_req", 32'(bus.ahbsram_req), 32'(0));
    check("hready_low_hreadyout", 32'(bus.HREADYOUT), 32'(1));
    drive_idle();
    hready_kill = 1'b0;
    @(negedge HCLK);
    check("hready_low_req_count", 32'(req_total - base), 32'(0));

    // Reset while waiting for a slow ack; the late ack must not disturb the idle slave.
    ack_delay = 6;
    @(negedge HCLK);
    drive_addr(mk(1, TrNseq, 1, SzW, 32'h100, 32'h0, 1, 0, 0, 32'h0));
    push_exp_req(mk(1, TrNseq, 1, SzW, 32'h100, 32'h0, 1, 0, 0, 32'h0));
    @(negedge HCLK);
    check("rst_req_pulse", 32'(bus.ahbsram_req), 32'(1));
    drive_idle();
    bus.HWDATA = 32'h55AA55AA;
    @(negedge HCLK);
    check("rst_wait_hreadyout", 32'(bus.HREADYOUT), 32'(0));
    #2 HRESETN = 1'b0;
    #1;
    check("rst_async_hreadyout", 32'(bus.HREADYOUT), 32'(1));
    check("rst_async_hresp", 32'(bus.HRESP), 32'(0));
    check("rst_async_req", 32'(bus.ahbsram_req), 32'(0));
    check("rst_async_write", 32'(bus.ahbsram_write), 32'(0));
    check("rst_async_size", 32'(bus.ahbsram_size), 32'(0));
    check("rst_async_addr", 32'(bus.ahbsram_addr), 32'(0));
    repeat (2) @(negedge HCLK);
    HRESETN = 1'b1;
    base = req_total;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge HCLK);
      if (bus.sramahb_ack === 1'b1) seen = 1'b1;
    end
    check("late_ack_seen", 32'(seen), 32'(1));
    @(negedge HCLK);
    check("late_ack_hreadyout", 32'(bus.HREADYOUT), 32'(1));
    check("late_ack_hresp", 32'(bus.HRESP), 32'(0));
    check("late_ack_req_count", 32'(req_total - base), 32'(0));
    ack_delay = 1;
    pend.push_back(mk(1, TrNseq, 1, SzW, 32'h104, 32'hA5A55A5A, 1, 0, 0, 32'h0));
    pend.push_back(mk(1, TrNseq, 0, SzW, 32'h104, 32'h0, 1, 0, 1, 32'hA5A55A5A));
    run_xfers("post_rst");
    check("post_rst_req_count", 32'(req_total - base), 32'(2));
    check("exp_req_queue_empty", 32'(exp_req_q.size()), 32'(0));

    repeat (2) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
